// File: rtl/rggen_bit_field_rc_event_capture.sv
// Event capture front end for a read-to-clear bit field: synchronises raw events,
// edge-detects them into one-cycle set pulses and records events lost to an already-set bit.
module rggen_bit_field_rc_event_capture #(
    parameter int             WIDTH         = 8,
    parameter int             SYNC_STAGES   = 2,
    parameter bit [WIDTH-1:0] RISE_EDGE     = '1,
    parameter bit [WIDTH-1:0] FALL_EDGE     = '0,
    parameter bit [WIDTH-1:0] INPUT_INITIAL = '0,
    parameter int             COUNT_WIDTH   = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [WIDTH-1:0]       i_event,
    input  logic [WIDTH-1:0]       i_enable,
    input  logic [WIDTH-1:0]       i_status,
    output logic [WIDTH-1:0]       o_set,
    output logic [WIDTH-1:0]       o_overflow,
    input  logic [WIDTH-1:0]       i_overflow_clear,
    output logic [COUNT_WIDTH-1:0] o_drop_count,
    input  logic                   i_drop_count_clear
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    logic [WIDTH-1:0]       sync;
    logic [WIDTH-1:0]       prev;
    logic [WIDTH-1:0]       rise;
    logic [WIDTH-1:0]       fall;
    logic [WIDTH-1:0]       det;
    logic [WIDTH-1:0]       drop;
    logic                   any_drop;
    logic [COUNT_WIDTH-1:0] count_next;

    if (SYNC_STAGES == 0) begin : g_no_sync
        assign sync = i_event;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                for (int k = 0; k < SYNC_STAGES; k++) begin
                    chain[k] <= INPUT_INITIAL;
                end
            end else begin
                chain[0] <= i_event;
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    chain[k] <= chain[k-1];
                end
            end
        end

        assign sync = chain[SYNC_STAGES-1];
    end

    // prev follows sync regardless of enable, so re-enabling a held level is not an edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev <= INPUT_INITIAL;
        end else begin
            prev <= sync;
        end
    end

    assign rise     = sync & ~prev & RISE_EDGE;
    assign fall     = ~sync & prev & FALL_EDGE;
    assign det      = (rise | fall) & i_enable;
    // A bit is already set if the field holds it or a set pulse for it is in flight
    assign drop     = det & (i_status | o_set);
    assign any_drop = |drop;

    always_comb begin
        count_next = o_drop_count;
        if (i_drop_count_clear) begin
            count_next = any_drop ? COUNT_WIDTH'(1) : '0;
        end else if (any_drop && (o_drop_count != COUNT_MAX)) begin
            count_next = o_drop_count + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_set        <= '0;
            o_overflow   <= '0;
            o_drop_count <= '0;
        end else begin
            o_set        <= det;
            o_overflow   <= (o_overflow & ~i_overflow_clear) | drop;
            o_drop_count <= count_next;
        end
    end

endmodule

// File: tb/tb_rggen_bit_field_rc_event_capture.sv
// Bench for the RC event capture block: two instances (2-stage sync with 4-bit counter,
// no sync with 8-bit counter) share stimulus and are checked against a history-based model.
module tb_rggen_bit_field_rc_event_capture;

    localparam logic [7:0] FALL = 8'h01;
    localparam logic [7:0] RISE = 8'hFF;
    localparam int MS  [2] = '{2, 0};
    localparam int CAP [2] = '{15, 255};

    logic       clk;
    logic       rst_n;
    logic [7:0] ev;
    logic [7:0] en;
    logic [7:0] st;
    logic [7:0] ovf_clr;
    logic       cnt_clr;
    logic [7:0] set_a, ovf_a, set_b, ovf_b;
    logic [3:0] cnt_a;
    logic [7:0] cnt_b;

    int checks = 0;
    int errors = 0;

    rggen_bit_field_rc_event_capture #(
        .WIDTH(8), .SYNC_STAGES(2), .RISE_EDGE(RISE), .FALL_EDGE(FALL),
        .INPUT_INITIAL(8'h00), .COUNT_WIDTH(4)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_event(ev), .i_enable(en), .i_status(st),
        .o_set(set_a), .o_overflow(ovf_a), .i_overflow_clear(ovf_clr),
        .o_drop_count(cnt_a), .i_drop_count_clear(cnt_clr)
    );

    rggen_bit_field_rc_event_capture #(
        .WIDTH(8), .SYNC_STAGES(0), .RISE_EDGE(RISE), .FALL_EDGE(FALL),
        .INPUT_INITIAL(8'h00), .COUNT_WIDTH(8)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_event(ev), .i_enable(en), .i_status(st),
        .o_set(set_b), .o_overflow(ovf_b), .i_overflow_clear(ovf_clr),
        .o_drop_count(cnt_b), .i_drop_count_clear(cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the synchronised level is simply the event sampled MS edges ago
    logic [7:0] hist [$];
    logic [7:0] m_prev [2];
    logic [7:0] m_set  [2];
    logic [7:0] m_ovf  [2];
    int         m_cnt  [2];

    always @(posedge clk or negedge rst_n) begin : model
        logic [7:0] sy, det, drop;
        if (!rst_n) begin
            hist = '{8'h00, 8'h00, 8'h00};
            for (int j = 0; j < 2; j++) begin
                m_prev[j] = 8'h00; m_set[j] = 8'h00; m_ovf[j] = 8'h00; m_cnt[j] = 0;
            end
        end else begin
            hist.push_back(ev);
            if (hist.size() > 4) void'(hist.pop_front());
            for (int j = 0; j < 2; j++) begin
                sy   = hist[hist.size() - 1 - MS[j]];
                det  = ((sy & ~m_prev[j] & RISE) | (~sy & m_prev[j] & FALL)) & en;
                drop = det & (st | m_set[j]);
                m_ovf[j] = (m_ovf[j] & ~ovf_clr) | drop;
                if (cnt_clr) m_cnt[j] = (drop != 0) ? 1 : 0;
                else if (drop != 0) m_cnt[j] = (m_cnt[j] + 1 > CAP[j]) ? CAP[j] : m_cnt[j] + 1;
                m_set[j]  = det;
                m_prev[j] = sy;
            end
        end
    end

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_all();
        ovf_clr = 8'hFF; cnt_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 8'h00; cnt_clr = 1'b0;
        settle(1);
    endtask

    task automatic test_reset();
        settle(3);
        checks += 6;
        if (set_a !== 8'h00) begin errors++; $display("FAIL reset_set_a got %h exp 00", set_a); end
        if (ovf_a !== 8'h00) begin errors++; $display("FAIL reset_ovf_a got %h exp 00", ovf_a); end
        if (cnt_a !== 4'h0)  begin errors++; $display("FAIL reset_cnt_a got %h exp 0", cnt_a); end
        if (set_b !== 8'h00) begin errors++; $display("FAIL reset_set_b got %h exp 00", set_b); end
        if (ovf_b !== 8'h00) begin errors++; $display("FAIL reset_ovf_b got %h exp 00", ovf_b); end
        if (cnt_b !== 8'h00) begin errors++; $display("FAIL reset_cnt_b got %h exp 00", cnt_b); end
        rst_n = 1'b1;
        settle(4);
    endtask

    task automatic test_rise_latency();
        ev = 8'h08;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks += 2;
            if (set_a !== ((c == 2) ? 8'h08 : 8'h00))
                begin errors++; $display("FAIL rise_lat_a c=%0d got %h", c, set_a); end
            if (set_b !== ((c == 0) ? 8'h08 : 8'h00))
                begin errors++; $display("FAIL rise_lat_b c=%0d got %h", c, set_b); end
        end
        ev = 8'h00;
        settle(4);
    endtask

    task automatic test_any_edge();
        clear_all();
        for (int c = 0; c < 8; c++) begin
            if (c < 3) ev[0] = (c != 1);
            @(negedge clk);
            checks += 2;
            if (set_b[0] !== (c < 3))
                begin errors++; $display("FAIL toggle_set_b c=%0d got %b", c, set_b[0]); end
            if (set_a[0] !== (c >= 2 && c < 5))
                begin errors++; $display("FAIL toggle_set_a c=%0d got %b", c, set_a[0]); end
        end
        checks += 4;
        if (ovf_a !== 8'h01) begin errors++; $display("FAIL toggle_ovf_a got %h exp 01", ovf_a); end
        if (ovf_b !== 8'h01) begin errors++; $display("FAIL toggle_ovf_b got %h exp 01", ovf_b); end
        if (cnt_a !== 4'd2)  begin errors++; $display("FAIL toggle_cnt_a got %0d exp 2", cnt_a); end
        if (cnt_b !== 8'd2)  begin errors++; $display("FAIL toggle_cnt_b got %0d exp 2", cnt_b); end
        ev[0] = 1'b0;
        settle(4);
    endtask

    task automatic test_status_drop();
        clear_all();
        st = 8'h01; ev[0] = 1'b1;
        @(negedge clk);
        checks += 4;
        if (set_b !== 8'h01) begin errors++; $display("FAIL stat_set_b got %h exp 01", set_b); end
        if (ovf_b !== 8'h01) begin errors++; $display("FAIL stat_ovf_b got %h exp 01", ovf_b); end
        if (cnt_b !== 8'd1)  begin errors++; $display("FAIL stat_cnt_b got %0d exp 1", cnt_b); end
        if (set_a !== 8'h00) begin errors++; $display("FAIL stat_set_a0 got %h exp 00", set_a); end
        @(negedge clk);
        checks++;
        if (set_b !== 8'h00) begin errors++; $display("FAIL stat_set_b1 got %h exp 00", set_b); end
        @(negedge clk);
        checks += 3;
        if (set_a !== 8'h01) begin errors++; $display("FAIL stat_set_a got %h exp 01", set_a); end
        if (ovf_a !== 8'h01) begin errors++; $display("FAIL stat_ovf_a got %h exp 01", ovf_a); end
        if (cnt_a !== 4'd1)  begin errors++; $display("FAIL stat_cnt_a got %0d exp 1", cnt_a); end
        ev[0] = 1'b0; ovf_clr = 8'h01;
        @(negedge clk);
        checks += 4;
        if (set_b !== 8'h01) begin errors++; $display("FAIL clrwin_set_b got %h exp 01", set_b); end
        if (ovf_b !== 8'h01) begin errors++; $display("FAIL clrwin_ovf_b got %h exp 01", ovf_b); end
        if (cnt_b !== 8'd2)  begin errors++; $display("FAIL clrwin_cnt_b got %0d exp 2", cnt_b); end
        if (ovf_a !== 8'h00) begin errors++; $display("FAIL clr_ovf_a got %h exp 00", ovf_a); end
        ovf_clr = 8'h00;
        @(negedge clk);
        ovf_clr = 8'h01;
        @(negedge clk);
        checks += 4;
        if (set_a !== 8'h01) begin errors++; $display("FAIL clrwin_set_a got %h exp 01", set_a); end
        if (ovf_a !== 8'h01) begin errors++; $display("FAIL clrwin_ovf_a got %h exp 01", ovf_a); end
        if (cnt_a !== 4'd2)  begin errors++; $display("FAIL clrwin_cnt_a got %0d exp 2", cnt_a); end
        if (ovf_b !== 8'h00) begin errors++; $display("FAIL clr_ovf_b got %h exp 00", ovf_b); end
        ovf_clr = 8'h00; st = 8'h00;
        settle(4);
    endtask

    task automatic test_enable_gate();
        clear_all();
        en[5] = 1'b0; ev[5] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) en[5] = 1'b1;
            @(negedge clk);
            checks += 2;
            if (set_a[5] !== 1'b0) begin errors++; $display("FAIL gate_set_a c=%0d got %b exp 0", c, set_a[5]); end
            if (set_b[5] !== 1'b0) begin errors++; $display("FAIL gate_set_b c=%0d got %b exp 0", c, set_b[5]); end
        end
        ev[5] = 1'b0;
        settle(3);
        ev[5] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks += 2;
            if (set_b[5] !== (c == 0)) begin errors++; $display("FAIL regate_set_b c=%0d got %b", c, set_b[5]); end
            if (set_a[5] !== (c == 2)) begin errors++; $display("FAIL regate_set_a c=%0d got %b", c, set_a[5]); end
        end
        ev[5] = 1'b0;
        settle(4);
    endtask

    task automatic test_saturate();
        clear_all();
        st = 8'h01;
        for (int c = 0; c < 20; c++) begin
            ev[0] = ~ev[0];
            @(negedge clk);
        end
        settle(4);
        checks += 2;
        if (cnt_a !== 4'd15) begin errors++; $display("FAIL sat_cnt_a got %0d exp 15", cnt_a); end
        if (cnt_b !== 8'd20) begin errors++; $display("FAIL sat_cnt_b got %0d exp 20", cnt_b); end
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        checks += 2;
        if (cnt_a !== 4'd0) begin errors++; $display("FAIL cclr_cnt_a got %0d exp 0", cnt_a); end
        if (cnt_b !== 8'd0) begin errors++; $display("FAIL cclr_cnt_b got %0d exp 0", cnt_b); end
        ev[0] = 1'b1; cnt_clr = 1'b1;
        @(negedge clk);
        checks += 2;
        if (cnt_b !== 8'd1) begin errors++; $display("FAIL cclr_drop_cnt_b got %0d exp 1", cnt_b); end
        if (cnt_a !== 4'd0) begin errors++; $display("FAIL cclr_nodrop_cnt_a got %0d exp 0", cnt_a); end
        cnt_clr = 1'b0;
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        checks += 2;
        if (cnt_a !== 4'd1) begin errors++; $display("FAIL cclr_drop_cnt_a got %0d exp 1", cnt_a); end
        if (cnt_b !== 8'd0) begin errors++; $display("FAIL cclr_nodrop_cnt_b got %0d exp 0", cnt_b); end
        cnt_clr = 1'b0; st = 8'h00; ev[0] = 1'b0;
        settle(4);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            ev      = 8'($urandom);
            en      = 8'($urandom) | 8'($urandom);
            st      = 8'($urandom) & 8'($urandom);
            ovf_clr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            cnt_clr = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            checks += 6;
            if (set_a !== m_set[0]) begin errors++; $display("FAIL rnd_set_a c=%0d got %h exp %h", c, set_a, m_set[0]); end
            if (ovf_a !== m_ovf[0]) begin errors++; $display("FAIL rnd_ovf_a c=%0d got %h exp %h", c, ovf_a, m_ovf[0]); end
            if (int'(cnt_a) !== m_cnt[0]) begin errors++; $display("FAIL rnd_cnt_a c=%0d got %0d exp %0d", c, cnt_a, m_cnt[0]); end
            if (set_b !== m_set[1]) begin errors++; $display("FAIL rnd_set_b c=%0d got %h exp %h", c, set_b, m_set[1]); end
            if (ovf_b !== m_ovf[1]) begin errors++; $display("FAIL rnd_ovf_b c=%0d got %h exp %h", c, ovf_b, m_ovf[1]); end
            if (int'(cnt_b) !== m_cnt[1]) begin errors++; $display("FAIL rnd_cnt_b c=%0d got %0d exp %0d", c, cnt_b, m_cnt[1]); end
        end
        ev = 8'h00; en = 8'hFF; st = 8'h00; ovf_clr = 8'h00; cnt_clr = 1'b0;
        settle(4);
    endtask

    task automatic test_reset_mid();
        st = 8'hFF; ev = 8'hFF;
        settle(3);
        checks++;
        if (set_a !== 8'hFF) begin errors++; $display("FAIL mid_pre_set_a got %h exp ff", set_a); end
        rst_n = 1'b0;
        #1;
        checks += 6;
        if (set_a !== 8'h00) begin errors++; $display("FAIL mid_set_a got %h exp 00", set_a); end
        if (ovf_a !== 8'h00) begin errors++; $display("FAIL mid_ovf_a got %h exp 00", ovf_a); end
        if (cnt_a !== 4'h0)  begin errors++; $display("FAIL mid_cnt_a got %h exp 0", cnt_a); end
        if (set_b !== 8'h00) begin errors++; $display("FAIL mid_set_b got %h exp 00", set_b); end
        if (ovf_b !== 8'h00) begin errors++; $display("FAIL mid_ovf_b got %h exp 00", ovf_b); end
        if (cnt_b !== 8'h00) begin errors++; $display("FAIL mid_cnt_b got %h exp 00", cnt_b); end
        st = 8'h00;
        settle(2);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks += 2;
            if (set_b !== ((c == 0) ? 8'hFF : 8'h00))
                begin errors++; $display("FAIL rel_set_b c=%0d got %h", c, set_b); end
            if (set_a !== ((c == 2) ? 8'hFF : 8'h00))
                begin errors++; $display("FAIL rel_set_a c=%0d got %h", c, set_a); end
        end
    endtask

    initial begin
        rst_n = 1'b0; ev = 8'h00; en = 8'hFF; st = 8'h00; ovf_clr = 8'h00; cnt_clr = 1'b0;
        test_reset();
        test_rise_latency();
        test_any_edge();
        test_status_drop();
        test_enable_gate();
        test_saturate();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
